// File: rtl/seq_add32_sched_if.sv
// Operand/result handshake bundle for seq_add32_sched.
// Optional ovf signal present only when SEQ_ADD_OVF_EN is defined.
interface seq_add32_sched_if #(
    parameter int DATA_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic              op_sub;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic              c_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] sum;
    logic              c_out;
    logic              busy;
`ifdef SEQ_ADD_OVF_EN
    logic              ovf;
`endif

    modport master (
        output in_valid, op_sub, x, y, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, busy
`ifdef SEQ_ADD_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, op_sub, x, y, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, busy
`ifdef SEQ_ADD_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/seq_add32_sched.sv
// Multi-cycle add/sub: one 16-bit adder time-shared over NSEG segments.
// Define SEQ_ADD_OVF_EN to add the registered signed-overflow output.
module full_adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {16'd0, cin};
endmodule

module seq_add32_sched #(
    parameter int NSEG  = 2,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    seq_add32_sched_if.slave   bus
);
    localparam int DATA_W = 16 * NSEG;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [CNT_W-1:0] LAST_SEG = CNT_W'(NSEG - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  seg_cnt_q, seg_cnt_d;
    logic              carry_q, carry_d;
    logic [DATA_W-1:0] xr_q, xr_d;
    logic [DATA_W-1:0] yr_q, yr_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              c_out_q, c_out_d;
    logic              out_valid_q, out_valid_d;
`ifdef SEQ_ADD_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic [15:0] seg_a, seg_b, fa_s;
    logic        fa_co;

    // Segment select for the shared adder
    always_comb begin
        seg_a = '0;
        seg_b = '0;
        for (int i = 0; i < NSEG; i++) begin
            if (seg_cnt_q == CNT_W'(i)) begin
                seg_a = xr_q[16*i +: 16];
                seg_b = yr_q[16*i +: 16];
            end
        end
    end

    full_adder_16bit u_fa (
        .a    (seg_a),
        .b    (seg_b),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    always_comb begin
        state_d     = state_q;
        seg_cnt_d   = seg_cnt_q;
        carry_d     = carry_q;
        xr_d        = xr_q;
        yr_d        = yr_q;
        sum_d       = sum_q;
        c_out_d     = c_out_q;
        out_valid_d = out_valid_q;
`ifdef SEQ_ADD_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Subtract is x + ~y + ~borrow, so the adder never changes
                if (bus.in_valid) begin
                    xr_d      = bus.x;
                    yr_d      = bus.op_sub ? ~bus.y : bus.y;
                    carry_d   = bus.op_sub ? ~bus.c_in : bus.c_in;
                    seg_cnt_d = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < NSEG; i++) begin
                    if (seg_cnt_q == CNT_W'(i))
                        sum_d[16*i +: 16] = fa_s;
                end
                carry_d   = fa_co;
                seg_cnt_d = seg_cnt_q + CNT_W'(1);
                if (seg_cnt_q == LAST_SEG) begin
                    state_d     = S_DONE;
                    c_out_d     = fa_co;
                    out_valid_d = 1'b1;
`ifdef SEQ_ADD_OVF_EN
                    // a^b^s at the MSB recovers the carry into it
                    ovf_d = seg_a[15] ^ seg_b[15] ^ fa_s[15] ^ fa_co;
`endif
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            seg_cnt_q   <= '0;
            carry_q     <= 1'b0;
            xr_q        <= '0;
            yr_q        <= '0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SEQ_ADD_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            seg_cnt_q   <= seg_cnt_d;
            carry_q     <= carry_d;
            xr_q        <= xr_d;
            yr_q        <= yr_d;
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            out_valid_q <= out_valid_d;
`ifdef SEQ_ADD_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
`ifdef SEQ_ADD_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: doc/seq_add32_sched.md
Name: seq_add32_sched

Overview:
- Multi-cycle add/subtract scheduler that time-shares one `full_adder_16bit` instance across NSEG 16-bit segments of a wide operand.
- Default NSEG=2 gives a 32-bit add in 2 compute cycles, which is area-reduced compared with two parallel 16-bit adders.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Owns the segment counter, the carry register and the result buffer.

Parameters:
- NSEG, 2, number of 16-bit segments; DATA_W = 16*NSEG; legal range 1..8.
- CNT_W, 3, segment counter width; must satisfy 2^CNT_W >= NSEG.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- in_valid  input  1  operand request
- in_ready  output  1  block can accept an operand
- op_sub  input  1  0 = x+y+c_in; 1 = x-y-c_in (borrow-in)
- x  input  DATA_W  operand A
- y  input  DATA_W  operand B
- c_in  input  1  carry-in (add) or borrow-in (sub)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- sum  output  DATA_W  result
- c_out  output  1  carry-out (add) or NOT-borrow (sub)
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - state=IDLE, seg_cnt=0, carry reg=0, sum=0, c_out=0, out_valid=0, busy=0.
  - Any operation in flight is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid&&in_ready at an edge:
    - Latch x into xr.
    - Latch y into yr, stored as op_sub ? ~y : y.
    - Load carry reg with op_sub ? ~c_in : c_in.
    - seg_cnt=0, go to RUN.
  - Inputs are don't-care after acceptance.
- RUN:
  - in_ready=0.
  - Adder inputs: xr[16*seg_cnt +: 16], yr[16*seg_cnt +: 16], carry reg.
  - Each edge:
    - Write the adder sum into the sum[16*seg_cnt +: 16] buffer.
    - Carry reg <= adder carry-out.
    - seg_cnt++.
  - After the segment NSEG-1 edge: go to DONE, c_out <= final carry, out_valid <= 1.
- DONE:
  - sum/c_out held stable while out_valid=1.
  - out_valid&&out_ready at an edge: out_valid <= 0, go to IDLE.
  - No new acceptance in the same cycle.
- Latency and throughput:
  - out_valid rises NSEG edges after the acceptance edge.
  - Minimum issue interval is NSEG+2 cycles (accept, NSEG RUN cycles, DONE with out_ready=1).
- sum and c_out keep their last values in IDLE. They are not cleared except by reset.
- Arithmetic is modulo 2^DATA_W; carry propagates between segments only through the carry reg.
- Boundary cases:
  - out_ready held high before DONE has no effect.
  - in_valid during RUN/DONE is ignored; the producer must hold it until in_ready.
  - reset_n=0 in any state forces IDLE on that edge, regardless of other inputs.
  - NSEG=1: RUN lasts exactly one cycle.

Optional Feature:
- Macro: SEQ_ADD_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit).
  - During the last RUN cycle, register ovf = carry into bit DATA_W-1 XOR carry out of bit DATA_W-1 (two's-complement signed overflow for both add and sub).
  - ovf is valid and held with out_valid; reset value 0.
- Undefined: no ovf port and no related logic. All other behaviour is identical.

Test Plan:
- Reset then basic add, NSEG=2:
  - Stimulus: x=0x0000FFFF, y=0x00000001, c_in=0, op_sub=0.
  - Expect: out_valid 2 edges after accept; sum=0x00010000, c_out=0 (inter-segment carry checked).
- Full wrap:
  - Stimulus: x=0xFFFFFFFF, y=0x00000000, c_in=1.
  - Expect: sum=0x00000000, c_out=1; with SEQ_ADD_OVF_EN, ovf=0.
- Subtract:
  - Stimulus: op_sub=1, x=5, y=7, c_in=0.
  - Expect: sum=0xFFFFFFFE, c_out=0 (borrow).
  - Stimulus: x=0x80000000, y=1.
  - Expect: sum=0x7FFFFFFF, c_out=1, ovf=1.
- Back-pressure:
  - Stimulus: out_ready=0 for 5 cycles in DONE; toggle x/y/in_valid meanwhile.
  - Expect: sum/c_out/out_valid stable, in_ready=0; release out_ready → IDLE next edge, in_ready=1.
- Reset mid-op:
  - Stimulus: assert reset_n=0 on the first RUN cycle.
  - Expect: next edge state=IDLE, out_valid=0, sum=0, busy=0; a following add 3+4 returns 7.
- Parameter sweep:
  - Stimulus: NSEG=4, x=0x0000_FFFF_FFFF_FFFF, y=1.
  - Expect: sum=0x0001_0000_0000_0000 after 4 RUN cycles, busy high throughout.
